// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard sources in,
// pipeline enables, flush/bubble controls and stall counter out.
interface hazard_ctrl_if;
  logic [15:0] ID_Instr;
  logic        ID_usesRs;
  logic        ID_usesRt;
  logic        IE_memRead;
  logic [2:0]  IE_writereg;
  logic        IE_branchTaken;
  logic        IF_memStall;
  logic        M_memStall;
  logic        stall_cnt_clr;
  logic        PC_write;
  logic        IFID_write;
  logic        IFID_flush;
  logic        IDIE_bubble;
  logic        pipe_hold;
  logic        squashing;
  logic [15:0] stall_cnt;

  modport master (
    output ID_Instr, ID_usesRs, ID_usesRt,
    output IE_memRead, IE_writereg,
    output IE_branchTaken, IF_memStall,
    output M_memStall, stall_cnt_clr,
    input  PC_write, IFID_write, IFID_flush,
    input  IDIE_bubble, pipe_hold,
    input  squashing, stall_cnt
  );

  modport slave (
    input  ID_Instr, ID_usesRs, ID_usesRt,
    input  IE_memRead, IE_writereg,
    input  IE_branchTaken, IF_memStall,
    input  M_memStall, stall_cnt_clr,
    output PC_write, IFID_write, IFID_flush,
    output IDIE_bubble, pipe_hold,
    output squashing, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use, cache-miss and branch hazard control for the
// five-stage core, with stale-fetch squash FSM and stall counter.
module hazard_ctrl (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        ld_use;
  logic        rs_hit;
  logic        rt_hit;
  logic        pc_w;
  logic        ifid_w;
  logic        ifid_fl;
  logic        bubble;
  logic        hold;
  logic [15:0] cnt;

  assign rs_hit = hz.ID_usesRs &
                  (hz.IE_writereg == hz.ID_Instr[10:8]);
  assign rt_hit = hz.ID_usesRt &
                  (hz.IE_writereg == hz.ID_Instr[7:5]);
  assign ld_use = hz.IE_memRead & (rs_hit | rt_hit);

  // Priority chain: reset, data hold, branch, squash,
  // load-use, fetch stall, then free-running.
  always_comb begin
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    ifid_fl   = 1'b0;
    bubble    = 1'b0;
    hold      = 1'b0;
    state_nxt = state;
    if (rst) begin
      pc_w      = 1'b0;
      ifid_w    = 1'b0;
      ifid_fl   = 1'b1;
      bubble    = 1'b1;
      state_nxt = RUN;
    end else if (hz.M_memStall) begin
      hold   = 1'b1;
      pc_w   = 1'b0;
      ifid_w = 1'b0;
    end else if (hz.IE_branchTaken) begin
      ifid_fl = 1'b1;
      bubble  = 1'b1;
      if (hz.IF_memStall)
        state_nxt = SQUASH;
    end else if (state == SQUASH) begin
      pc_w    = 1'b0;
      ifid_fl = 1'b1;
      bubble  = ld_use;
      if (!hz.IF_memStall)
        state_nxt = RUN;
    end else if (ld_use) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      bubble = 1'b1;
    end else if (hz.IF_memStall) begin
      pc_w    = 1'b0;
      ifid_fl = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (hz.stall_cnt_clr)
        cnt <= '0;
      else if (!pc_w && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
    end
  end

  assign hz.PC_write    = pc_w;
  assign hz.IFID_write  = ifid_w;
  assign hz.IFID_flush  = ifid_fl;
  assign hz.IDIE_bubble = bubble;
  assign hz.pipe_hold   = hold;
  assign hz.squashing   = (state == SQUASH) & ~rst;
  assign hz.stall_cnt   = cnt;

endmodule
